queue: RTL and testbench

Write-data-channel ordering FIFO for the AXI4 interconnect. Each write-address grant pushes the granted ID and its split-burst flag. The head entry selects which source drives the write-data channel. The entry is popped when that write-data burst finishes, so W beats are routed in AW grant order.

---
 rtl/queue_if.sv | 29 ++
 rtl/queue.sv | 79 +++++++
 tb/tb_queue.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/queue_if.sv
// Write-data ordering queue bus: push side (AW grant) and pop side (W burst end)
// plus the head-of-queue outputs that steer the write-data channel.
interface queue_if #(
    parameter int ID_Size = 1
);
    logic               AW_Access_Grant;
    logic [ID_Size-1:0] Slave_ID;
    logic               Is_Transaction_Part_of_Split;
    logic               Write_Data_Finsh;
    logic               Queue_Is_Full;
    logic               Write_Data_HandShake_En_Pulse;
    logic               Is_Master_Part_Of_Split;
    logic               Master_Valid;
    logic [ID_Size-1:0] Write_Data_Master;

    // Driver of the push/pop requests; observes the head state.
    modport master (
        output AW_Access_Grant, Slave_ID, Is_Transaction_Part_of_Split, Write_Data_Finsh,
        input  Queue_Is_Full, Write_Data_HandShake_En_Pulse, Is_Master_Part_Of_Split,
               Master_Valid, Write_Data_Master
    );

    // The queue itself.
    modport slave (
        input  AW_Access_Grant, Slave_ID, Is_Transaction_Part_of_Split, Write_Data_Finsh,
        output Queue_Is_Full, Write_Data_HandShake_En_Pulse, Is_Master_Part_Of_Split,
               Master_Valid, Write_Data_Master
    );
endinterface

// File: rtl/queue.sv
// Write-data-channel ordering FIFO. Each AW grant pushes {split, ID}; the head
// entry selects the W source and is popped when that W burst completes, so W
// beats follow AW grant order. Head outputs are show-ahead from registered state.
module queue #(
    parameter int Slaves_Num  = 2,
    parameter int ID_Size     = (Slaves_Num > 1) ? $clog2(Slaves_Num) : 1,
    parameter int Queue_Depth = 4
) (
    input logic    ACLK,
    input logic    ARESETN,   // active-high asynchronous reset despite the name
    queue_if.slave q_if
);
    localparam int PTR_W = $clog2(Queue_Depth);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(Queue_Depth);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [ID_Size-1:0] id_mem_q    [Queue_Depth];
    logic               split_mem_q [Queue_Depth];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pulse_q, pulse_d;
    logic             push, pop;

    // Decide push/pop and the next pointer, count and head-change pulse values.
    always_comb begin
        pop      = q_if.Write_Data_Finsh && (count_q != '0);
        // A full queue still accepts a push when the head leaves in the same cycle.
        push     = q_if.AW_Access_Grant && ((count_q != DEPTH_C) || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + ONE_C;
        end else if (pop && !push) begin
            count_d = count_q - ONE_C;
        end
        // A fresh entry reaches the head: first entry into an empty queue, or a
        // pop that leaves another entry (already queued or arriving now) behind.
        pulse_d = (push && (count_q == '0)) || (pop && ((count_q > ONE_C) || push));
    end

    // Control state: pointers, occupancy and the handshake pulse.
    always_ff @(posedge ACLK or posedge ARESETN) begin
        if (ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pulse_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pulse_q  <= pulse_d;
        end
    end

    // Entry storage; contents are qualified by count so they need no reset.
    always_ff @(posedge ACLK) begin
        if (push) begin
            id_mem_q[wr_ptr_q]    <= q_if.Slave_ID;
            split_mem_q[wr_ptr_q] <= q_if.Is_Transaction_Part_of_Split;
        end
    end

    assign q_if.Master_Valid                  = (count_q != '0);
    assign q_if.Queue_Is_Full                 = (count_q == DEPTH_C);
    assign q_if.Write_Data_Master             = (count_q != '0) ? id_mem_q[rd_ptr_q] : '0;
    assign q_if.Is_Master_Part_Of_Split       = (count_q != '0) ? split_mem_q[rd_ptr_q] : 1'b0;
    assign q_if.Write_Data_HandShake_En_Pulse = pulse_q;
endmodule

// File: tb/tb_queue.sv
// Self-checking bench for the write-data ordering queue: directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
module tb_queue;
    localparam int ID_W  = 1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   model_on = 1'b1;

    queue_if #(.ID_Size(ID_W)) bus ();

    queue #(.Slaves_Num(2), .ID_Size(ID_W), .Queue_Depth(DEPTH)) dut (
        .ACLK    (clk),
        .ARESETN (rst),
        .q_if    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of {split, id}; the pulse marks any edge
    // after which a newly arrived entry sits at the head.
    logic [ID_W:0] mq[$];
    bit            m_pulse;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_pulse = 1'b0;
        end else begin
            bit do_pop, do_push;
            int n;
            n       = mq.size();
            do_pop  = bus.Write_Data_Finsh && (n > 0);
            do_push = bus.AW_Access_Grant && ((n < DEPTH) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({bus.Is_Transaction_Part_of_Split, bus.Slave_ID});
            m_pulse = (do_push && n == 0) || (do_pop && mq.size() > 0);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Every cycle out of reset, the DUT outputs must match the model.
    always @(negedge clk) begin
        if (!rst && model_on) begin
            int n;
            n = mq.size();
            chk("m_valid", int'(bus.Master_Valid), (n != 0) ? 1 : 0);
            chk("m_full",  int'(bus.Queue_Is_Full), (n == DEPTH) ? 1 : 0);
            chk("m_head",  int'(bus.Write_Data_Master), (n != 0) ? int'(mq[0][ID_W-1:0]) : 0);
            chk("m_split", int'(bus.Is_Master_Part_Of_Split), (n != 0) ? int'(mq[0][ID_W]) : 0);
            chk("m_pulse", int'(bus.Write_Data_HandShake_En_Pulse), int'(m_pulse));
        end
    end

    // One clock: drive inputs, let the edge happen, land just after the falling edge.
    task automatic step(input bit g, input int id, input bit sp, input bit f);
        bus.AW_Access_Grant              = g;
        bus.Slave_ID                     = ID_W'(id);
        bus.Is_Transaction_Part_of_Split = sp;
        bus.Write_Data_Finsh             = f;
        @(negedge clk);
        #1;
        bus.AW_Access_Grant              = 1'b0;
        bus.Write_Data_Finsh             = 1'b0;
        bus.Is_Transaction_Part_of_Split = 1'b0;
    endtask

    task automatic chk_out(input string nm, input int v, input int f, input int h, input int s, input int p);
        chk({nm, "_valid"}, int'(bus.Master_Valid), v);
        chk({nm, "_full"},  int'(bus.Queue_Is_Full), f);
        chk({nm, "_head"},  int'(bus.Write_Data_Master), h);
        chk({nm, "_split"}, int'(bus.Is_Master_Part_Of_Split), s);
        chk({nm, "_pulse"}, int'(bus.Write_Data_HandShake_En_Pulse), p);
    endtask

    initial begin
        bus.AW_Access_Grant              = 1'b0;
        bus.Slave_ID                     = '0;
        bus.Is_Transaction_Part_of_Split = 1'b0;
        bus.Write_Data_Finsh             = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_out("rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0);
        chk_out("idle", 0, 0, 0, 0, 0);

        // Single push then pop.
        step(1, 0, 0, 0);  chk_out("push1", 1, 0, 0, 0, 1);
        step(0, 0, 0, 0);  chk_out("hold1", 1, 0, 0, 0, 0);
        step(0, 0, 0, 1);  chk_out("pop1", 0, 0, 0, 0, 0);

        // FIFO order.
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);  chk_out("ord_h0", 1, 0, 0, 0, 0);
        step(0, 0, 0, 1);  chk_out("ord_h1", 1, 0, 1, 0, 1);
        step(0, 0, 0, 1);  chk_out("ord_e", 0, 0, 0, 0, 0);

        // Full, ignored fifth push, drain.
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
        chk_out("full4", 1, 1, 1, 0, 0);
        step(1, 0, 0, 0);  chk_out("full5", 1, 1, 1, 0, 0);
        step(0, 0, 0, 1);  chk_out("drain1", 1, 0, 0, 0, 1);
        step(0, 0, 0, 1);  chk_out("drain2", 1, 0, 1, 0, 1);
        step(0, 0, 0, 1);  chk_out("drain3", 1, 0, 0, 0, 1);
        step(0, 0, 0, 1);  chk_out("drain4", 0, 0, 0, 0, 0);

        // Split flag follows its entry.
        step(1, 1, 1, 0); step(1, 0, 0, 0);
        chk_out("split1", 1, 0, 1, 1, 0);
        step(0, 0, 0, 1);  chk_out("split0", 1, 0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Simultaneous push+pop at count 1 and at full.
        step(1, 0, 0, 0);
        step(1, 1, 0, 1);  chk_out("pp1", 1, 0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
        step(1, 1, 0, 1);  chk_out("ppf", 1, 1, 0, 0, 1);
        step(0, 0, 0, 1);  chk_out("ppf_d1", 1, 0, 1, 0, 1);
        step(0, 0, 0, 1);  chk_out("ppf_d2", 1, 0, 0, 0, 1);
        step(0, 0, 0, 1);  chk_out("ppf_d3", 1, 0, 1, 0, 1);
        step(0, 0, 0, 1);  chk_out("ppf_d4", 0, 0, 0, 0, 0);

        // Reset mid-operation with three entries.
        step(1, 1, 1, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        rst = 1'b1;
        #1;
        chk_out("arst", 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 1);  chk_out("pop_empty", 0, 0, 0, 0, 0);
        step(1, 1, 1, 0);  chk_out("post_rst", 1, 0, 1, 1, 1);
        step(0, 0, 0, 1);

        // Randomized traffic checked every cycle by the model comparator.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 55), int'($urandom_range(1)),
                 bit'($urandom_range(1)), ($urandom_range(99) < 45));
        end
        // Bias toward filling, then toward draining, to dwell at both limits.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 85), int'($urandom_range(1)),
                 bit'($urandom_range(1)), ($urandom_range(99) < 20));
        end
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 15), int'($urandom_range(1)),
                 bit'($urandom_range(1)), ($urandom_range(99) < 85));
        end

        model_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
